// File: rtl/auto_bcd_counter.sv
// Multi-digit BCD up/down counter paced by a free-running prescaler tick,
// with active-low seven-segment decode per digit and tick/wrap outputs for chaining.
module auto_bcd_counter #(
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_HZ  = 1,
    parameter int DIGITS   = 2,
    parameter int MODULO   = 100,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic                  CLOCK_50,
    input  logic                  KEY0,
    input  logic                  SW_EN,
    input  logic                  SW_DIR,
    input  logic                  SW_CLR,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [4*DIGITS-1:0]   COUNT_BCD,
    output logic                  TICK,
    output logic                  WRAP
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int CW  = 4 * DIGITS;

    function automatic logic [CW-1:0] to_bcd(input int unsigned v);
        logic [CW-1:0] r;
        int unsigned   x;
        r = '0;
        x = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Bit order is g..a, so segment a lands on bit 0 of each HEX slice.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    localparam logic [CW-1:0] MAX_BCD = to_bcd(MODULO - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick_q, tick_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wrap_q, wrap_d;
    logic [CW-1:0]     inc_val, dec_val;
    logic              any_bad;
    logic [DIGITS-1:0] blank;
    logic              presc_end;

    assign presc_end = (presc_q == PW'(DIV - 1));

    always_comb begin
        presc_d = presc_end ? '0 : presc_q + 1'b1;
        tick_d  = presc_end;
    end

    // Ripple BCD increment/decrement; carry and borrow walk up from digit 0.
    always_comb begin : bcd_step
        logic       c;
        logic       b;
        logic [3:0] d;
        c       = 1'b1;
        b       = 1'b1;
        d       = 4'd0;
        inc_val = '0;
        dec_val = '0;
        any_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            d       = count_q[4*k +: 4];
            any_bad = any_bad | (d > 4'd9);
            inc_val[4*k +: 4] = c ? ((d >= 4'd9) ? 4'd0 : d + 4'd1) : d;
            dec_val[4*k +: 4] = b ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
            c = c & (d >= 4'd9);
            b = b & (d == 4'd0);
        end
    end

    // Illegal or out-of-range values recover: up goes to 0 with wrap, down reloads the maximum.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (SW_CLR) begin
            count_d = '0;
        end else if (tick_q && SW_EN) begin
            if (!SW_DIR) begin
                if (any_bad || count_q >= MAX_BCD) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = inc_val;
                end
            end else begin
                if (any_bad || count_q > MAX_BCD) begin
                    count_d = MAX_BCD;
                end else if (count_q == '0) begin
                    count_d = MAX_BCD;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = dec_val;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // A digit above 0 blanks only while it and every digit above it are zero.
    always_comb begin : lz_blank
        logic z;
        z     = 1'b1;
        blank = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            z        = z & (count_q[4*k +: 4] == 4'd0);
            blank[k] = BLANK_LZ & z;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_hex
            assign HEX[7*gi +: 7] = blank[gi] ? 7'b1111111 : seg7(count_q[4*gi +: 4]);
        end
    endgenerate

    assign COUNT_BCD = count_q;
    assign TICK      = tick_q;
    assign WRAP      = wrap_q;

endmodule

// File: tb/tb_auto_bcd_counter.sv
// Bench for auto_bcd_counter: tick spacing, up/down wrap, clear priority,
// async reset mid-count and leading-zero blanking on a 3-digit instance.
module tb_auto_bcd_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        key0, sw_en, sw_dir, sw_clr;
    logic [13:0] hex;
    logic [7:0]  bcd;
    logic        tick, wrap;

    logic        key3, en3, dir3, clr3;
    logic [20:0] hex3;
    logic [11:0] bcd3;
    logic        tick3, wrap3;

    auto_bcd_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .MODULO(12), .BLANK_LZ(1'b0)) dut (
        .CLOCK_50(clk), .KEY0(key0), .SW_EN(sw_en), .SW_DIR(sw_dir), .SW_CLR(sw_clr),
        .HEX(hex), .COUNT_BCD(bcd), .TICK(tick), .WRAP(wrap));

    auto_bcd_counter #(.CLK_HZ(2), .TICK_HZ(1), .DIGITS(3), .MODULO(1000), .BLANK_LZ(1'b1)) dut3 (
        .CLOCK_50(clk), .KEY0(key3), .SW_EN(en3), .SW_DIR(dir3), .SW_CLR(clr3),
        .HEX(hex3), .COUNT_BCD(bcd3), .TICK(tick3), .WRAP(wrap3));

    typedef struct {
        logic       en;
        logic       dir;
        logic [7:0] exp_bcd;
        logic       exp_wrap;
    } vec_t;

    typedef struct {
        logic [7:0]  bcd;
        logic        wrap;
        logic [13:0] hex;
    } exp_t;

    vec_t vecs[18];
    exp_t sb[$];

    int passed = 0;
    int total  = 0;

    localparam logic [6:0] BLANK7 = 7'b1111111;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] hex2(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        return {seg(hi), seg(lo)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance negedge by negedge until TICK is seen high; n = negedges taken.
    task automatic wait_tick(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (tick === 1'b1) break;
        end
        if (tick !== 1'b1) check("tick_timeout", 32'(tick), 32'd1);
    endtask

    task automatic wait_bcd3(input logic [11:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bcd3 === target) break;
        end
        if (bcd3 !== target) check("bcd3_timeout", 32'(bcd3), 32'(target));
    endtask

    initial begin
        int   n;
        exp_t e;
        exp_t got;

        vecs[0]  = '{1'b1, 1'b0, 8'h01, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h02, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h03, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'h04, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h05, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h06, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h07, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h08, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h09, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h10, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'h11, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 8'h11, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 8'h10, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 8'h09, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 8'h08, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 8'h07, 1'b0};

        key0 = 1'b0; sw_en = 1'b0; sw_dir = 1'b0; sw_clr = 1'b0;
        key3 = 1'b0; en3 = 1'b1; dir3 = 1'b0; clr3 = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_bcd", 32'(bcd), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);
        check("reset_hex", 32'(hex), 32'(hex2(8'h00)));

        // Tick spacing with counting disabled
        key0 = 1'b1;
        wait_tick(n);
        check("first_tick_gap", 32'(n), 32'd10);
        @(negedge clk);
        check("tick_width", 32'(tick), 32'd0);
        wait_tick(n);
        check("tick_period", 32'(n + 1), 32'd10);
        check("hold_bcd", 32'(bcd), 32'h0);
        check("hold_hex", 32'(hex), 32'(hex2(8'h00)));
        @(negedge clk);

        // Table: each vector is applied for one tick, expectation queued then popped
        for (int v = 0; v < 18; v++) begin
            sw_en  = vecs[v].en;
            sw_dir = vecs[v].dir;
            e.bcd  = vecs[v].exp_bcd;
            e.wrap = vecs[v].exp_wrap;
            e.hex  = hex2(vecs[v].exp_bcd);
            sb.push_back(e);
            wait_tick(n);
            @(negedge clk);
            got = sb.pop_front();
            check($sformatf("vec%0d_bcd", v), 32'(bcd), 32'(got.bcd));
            check($sformatf("vec%0d_wrap", v), 32'(wrap), 32'(got.wrap));
            check($sformatf("vec%0d_hex", v), 32'(hex), 32'(got.hex));
            $display("vec %0d en=%0b dir=%0b bcd=%02h wrap=%0b", v, sw_en, sw_dir, bcd, wrap);
        end
        @(negedge clk);
        check("wrap_one_cycle", 32'(wrap), 32'd0);

        // Clear coincident with tick at 0x07
        wait_tick(n);
        sw_clr = 1'b1;
        @(negedge clk);
        sw_clr = 1'b0;
        sw_en  = 1'b0;
        check("clr_bcd", 32'(bcd), 32'h00);
        check("clr_wrap", 32'(wrap), 32'd0);
        check("clr_hex", 32'(hex), 32'(hex2(8'h00)));
        wait_tick(n);
        check("clr_phase", 32'(n + 1), 32'd10);
        @(negedge clk);

        // Count up to 0x05 then assert reset between edges
        sw_en = 1'b1; sw_dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_tick(n);
            @(negedge clk);
        end
        check("pre_reset_bcd", 32'(bcd), 32'h05);
        #2 key0 = 1'b0;
        #1;
        check("async_bcd", 32'(bcd), 32'h0);
        check("async_wrap", 32'(wrap), 32'h0);
        check("async_tick", 32'(tick), 32'h0);
        check("async_hex", 32'(hex), 32'(hex2(8'h00)));
        @(negedge clk);
        key0 = 1'b1;
        wait_tick(n);
        check("post_reset_tick_gap", 32'(n), 32'd10);
        @(negedge clk);
        check("post_reset_bcd", 32'(bcd), 32'h01);

        // Leading-zero blanking on the 3-digit instance
        key3 = 1'b1;
        wait_bcd3(12'h007, 100);
        check("blank_007", 32'(hex3), 32'({BLANK7, BLANK7, seg(4'd7)}));
        $display("blank bcd3=%03h hex3=%06h", bcd3, hex3);
        wait_bcd3(12'h010, 100);
        check("blank_010", 32'(hex3), 32'({BLANK7, seg(4'd1), seg(4'd0)}));
        $display("blank bcd3=%03h hex3=%06h", bcd3, hex3);
        wait_bcd3(12'h100, 400);
        check("blank_100", 32'(hex3), 32'({seg(4'd1), seg(4'd0), seg(4'd0)}));
        $display("blank bcd3=%03h hex3=%06h", bcd3, hex3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/auto_bcd_counter.md
Name: auto_bcd_counter

Overview:
- Parametrised successor to the single-digit automatic counter. Free-running prescaler derives a 1-cycle count tick from CLOCK_50.
- Multi-digit BCD counter runs up or down with a configurable modulus, and each digit drives one active-low seven-segment display.
- Sits between board switches/keys and the HEX displays in the lab top level; also exports the tick and a wrap pulse for chaining.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz. DIV = CLK_HZ/TICK_HZ, must be >= 2.
- DIGITS, 2, number of BCD digits / HEX displays, 1..8.
- MODULO, 100, count range 0..MODULO-1. Must satisfy 2 <= MODULO <= 10^DIGITS.
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 is never blanked).

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- KEY0  input  1  reset, asynchronous, active-low.
- SW_EN  input  1  count enable; 0 = hold value.
- SW_DIR  input  1  0 = count up, 1 = count down.
- SW_CLR  input  1  synchronous clear of the count value, active-high.
- HEX  output  7*DIGITS  segments; HEX[7k+0..7k+6] = segments a..g of digit k (k=0 is least significant), active-low.
- COUNT_BCD  output  4*DIGITS  current value, packed BCD, digit k at [4k+3:4k].
- TICK  output  1  one-cycle pulse at the count rate.
- WRAP  output  1  one-cycle pulse on the cycle the value wraps.

Behaviour:
- Reset (KEY0=0, asynchronous):
  - prescaler = 0, COUNT_BCD = 0, TICK = 0, WRAP = 0.
  - HEX shows "0" on digit 0; other digits show "0", or all-off if BLANK_LZ=1.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0. Period is exactly DIV cycles, with no off-by-one.
  - TICK is registered high for the single cycle after the prescaler reaches DIV-1.
  - Runs continuously and ignores SW_EN and SW_CLR.
- Count update priority, evaluated each rising edge:
  1. SW_CLR=1: value <= 0 and WRAP <= 0, regardless of TICK or SW_EN.
  2. TICK=1 and SW_EN=1 and SW_DIR=0: if value == MODULO-1, value <= 0 and WRAP <= 1; else value+1 with BCD carry across digits (9 -> 0, carry into the next digit).
  3. TICK=1 and SW_EN=1 and SW_DIR=1: if value == 0, value <= MODULO-1 and WRAP <= 1; else value-1 with BCD borrow (0 -> 9, borrow from the next digit).
  4. Otherwise: value holds and WRAP <= 0.
- Value advances on the edge where TICK is high, so COUNT_BCD changes one cycle after TICK rises. WRAP coincides with the new value.
- SW_DIR or SW_EN changes take effect at the next tick. No illegal BCD digit (>9) is ever stored.
- A value outside the range is unreachable. If one is forced, the next up-tick yields 0 with WRAP.
- Segment decode:
  - Combinational from COUNT_BCD, active-low, listed as g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other code gives 1111111.
  - BLANK_LZ=1: a digit k>0 is 1111111 when it and every higher digit are 0.
- Reset asserted mid-operation clears everything immediately. On release, the prescaler restarts from 0, so the first TICK comes DIV cycles after release.

Test Plan (CLK_HZ=10, TICK_HZ=1 so DIV=10; DIGITS=2, MODULO=12 unless stated):
- Tick spacing: release reset, hold SW_EN=0 -> TICK pulses every 10 cycles, each 1 cycle wide; COUNT_BCD stays 0x00 and HEX = {1000000,1000000}.
- Up-count with carry and wrap: SW_EN=1, SW_DIR=0, 12 ticks -> COUNT_BCD goes 00..09 then 0x10, 0x11, then 0x00 with WRAP=1 for 1 cycle on the 12th tick.
- Down-count with borrow: from 0x00, SW_DIR=1, one tick -> 0x11 with WRAP=1; after 2 more ticks -> 0x09.
- Clear priority: hold SW_CLR=1 on the same edge as TICK at value 0x07 -> value 0x00 and WRAP=0; prescaler phase unchanged.
- Async reset mid-count: drop KEY0 between clock edges at value 0x05 -> outputs zero immediately with no clock edge; first tick 10 cycles after release.
- Blanking: DIGITS=3, MODULO=1000, BLANK_LZ=1, value 0x007 -> HEX digits 2 and 1 = 1111111, digit 0 = 1111000; at value 0x100, digit 1 shows 1000000.
